// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, decoder jump/branch codes, fetch sequencer states.
package cpu_pkg;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_TYPEA = 4'b1111;

  localparam logic [2:0] JB_NONE = 3'b000;
  localparam logic [2:0] JB_BLT  = 3'b001;
  localparam logic [2:0] JB_BGT  = 3'b010;
  localparam logic [2:0] JB_BEQ  = 3'b011;
  localparam logic [2:0] JB_JMP  = 3'b100;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_issue_next_pc_calc.sv
// Combinational next-PC: sequential pc+2, plus a scaled 8-bit branch or 12-bit jump offset.
// Unknown jump/branch codes fall through to sequential; all sums wrap silently.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [11:0]       i_imm12,
  input  logic [2:0]        i_jump_branch,
  input  logic              i_cmp_lt,
  input  logic              i_cmp_gt,
  input  logic              i_cmp_eq,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_jmp_off;
  logic              w_taken;

  assign w_seq     = i_pc + ADDR_W'(2);
  // Offsets count halfwords, so append a zero LSB after sign extension.
  assign w_br_off  = {{(ADDR_W-9){i_imm12[7]}}, i_imm12[7:0], 1'b0};
  assign w_jmp_off = {{(ADDR_W-13){i_imm12[11]}}, i_imm12, 1'b0};

  always_comb begin
    w_taken = ((i_jump_branch == JB_BLT) && i_cmp_lt) ||
              ((i_jump_branch == JB_BGT) && i_cmp_gt) ||
              ((i_jump_branch == JB_BEQ) && i_cmp_eq);
    o_next_pc = w_seq;
    if (i_jump_branch == JB_JMP) begin
      o_next_pc = w_seq + w_jmp_off;
    end else if (w_taken) begin
      o_next_pc = w_seq + w_br_off;
    end
  end

endmodule

// File: rtl/fetch_issue.sv
// Fetch/issue sequencer: fetches one 16-bit instruction at pc, presents it until accepted, redirects pc.
// One cycle FETCH->ISSUE on zero-wait memory; issue stalls indefinitely while issue_ready is low.
module fetch_issue
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic               instr_valid,
  input  logic               issue_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [1:0]         multiDiv,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic [2:0]         jumpBranch,
  input  logic               cmp_lt,
  input  logic               cmp_gt,
  input  logic               cmp_eq,
  output logic               halted
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_latch;
  logic               w_accept;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_calc (
    .i_pc          (r_pc),
    .i_imm12       (r_instr[11:0]),
    .i_jump_branch (jumpBranch),
    .i_cmp_lt      (cmp_lt),
    .i_cmp_gt      (cmp_gt),
    .i_cmp_eq      (cmp_eq),
    .o_next_pc     (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // imem_valid is only honoured while a request is outstanding (FETCH/WAIT).
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      FETCH, WAIT: begin
        if (imem_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      ISSUE: begin
        if (issue_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = (r_instr[15:12] == OP_HALT) ? HALT : FETCH;
        end
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      if (w_latch) begin
        r_instr <= imem_rdata;
      end
      if (w_accept && (r_instr[15:12] != OP_HALT)) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign imem_req    = (r_state == FETCH) || (r_state == WAIT);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ISSUE);
  assign halted      = (r_state == HALT);
  assign instr       = r_instr;
  assign opcode      = r_instr[15:12];
  assign multiDiv    = r_instr[3:2];
  assign pc_out      = r_pc;

endmodule
